// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART line-echo stage.
//   echo_state_t : line-echo state machine encoding
//   ASCII_CR/LF  : carriage return / line feed byte values
package uart_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2,
    APPEND = 2'd3
  } echo_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous FIFO with wrapping pointers and a separate level
// counter, so full and empty never alias.
//   clock, reset     : system clock, asynchronous active-high reset
//   flush            : synchronous clear of pointers and level
//   push, wr_data    : write request (ignored when full)
//   pop, rd_data     : read request (ignored when empty); rd_data is the head
//   level            : occupancy, 0..DEPTH
//   full, empty      : occupancy flags
module byte_fifo #(
  parameter int DEPTH        = 16,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic                    pop,
  output logic [PAYLOAD_BITS-1:0] rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    push_ok;
  logic                    pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_line_echo.sv
// uart_line_echo: buffers received bytes and echoes them as a whole line once
// the terminator arrives or the buffer fills.
//   clock, reset        : system clock, asynchronous active-high reset
//   rx_valid, rx_byte   : received byte strobe and data
//   rx_break            : BREAK strobe, flushes everything
//   tx_busy             : transmitter busy
//   tx_enable, tx_byte  : transmit strobe and byte
//   level               : FIFO occupancy
//   overflow            : sticky, a byte was dropped on a full FIFO
// Build option: define UART_LINE_ECHO_CRLF_EN to follow every echoed CR with LF.
//
// state  | meaning
// FILL   | collecting a line, nothing transmitted
// SEND   | pop the head to the transmitter when it is idle; back to FILL when empty
// WAIT   | one guard cycle, then wait for tx_busy to drop
// APPEND | send LF after a CR (UART_LINE_ECHO_CRLF_EN only)
module uart_line_echo
  import uart_pkg::*;
#(
  parameter int                    DEPTH        = 16,
  parameter int                    PAYLOAD_BITS = 8,
  parameter logic [PAYLOAD_BITS-1:0] TERMINATOR = PAYLOAD_BITS'(ASCII_CR)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [PAYLOAD_BITS-1:0] rx_byte,
  input  logic                    rx_break,
  input  logic                    tx_busy,
  output logic                    tx_enable,
  output logic [PAYLOAD_BITS-1:0] tx_byte,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);

  localparam int LW = $clog2(DEPTH) + 1;

  echo_state_t             state;
  logic                    guard;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [PAYLOAD_BITS-1:0] fifo_head;
`ifdef UART_LINE_ECHO_CRLF_EN
  logic                    cr_popped;
`endif

  assign push = rx_valid && !rx_break && !fifo_full;
  assign pop  = (state == SEND) && !fifo_empty && !tx_busy && !rx_break;

  byte_fifo #(
    .DEPTH        (DEPTH),
    .PAYLOAD_BITS (PAYLOAD_BITS)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (rx_break),
    .push    (push),
    .wr_data (rx_byte),
    .pop     (pop),
    .rd_data (fifo_head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      guard     <= 1'b0;
      tx_enable <= 1'b0;
      tx_byte   <= '0;
      overflow  <= 1'b0;
`ifdef UART_LINE_ECHO_CRLF_EN
      cr_popped <= 1'b0;
`endif
    end else begin
      tx_enable <= 1'b0;
      if (rx_break) begin
        // tx_byte is left alone: a byte already handed over is not recalled.
        state    <= FILL;
        guard    <= 1'b0;
        overflow <= 1'b0;
`ifdef UART_LINE_ECHO_CRLF_EN
        cr_popped <= 1'b0;
`endif
      end else begin
        if (rx_valid && fifo_full) overflow <= 1'b1;
        case (state)
          FILL: begin
            if (push && (rx_byte == TERMINATOR || level == LW'(DEPTH - 1)))
              state <= SEND;
          end
          SEND: begin
            if (fifo_empty) begin
              state <= FILL;
            end else if (!tx_busy) begin
              tx_byte   <= fifo_head;
              tx_enable <= 1'b1;
              guard     <= 1'b1;
              state     <= WAIT;
`ifdef UART_LINE_ECHO_CRLF_EN
              cr_popped <= (fifo_head == PAYLOAD_BITS'(ASCII_CR));
`endif
            end
          end
          WAIT: begin
            // The transmitter raises busy only after seeing tx_enable.
            if (guard) begin
              guard <= 1'b0;
            end else if (!tx_busy) begin
`ifdef UART_LINE_ECHO_CRLF_EN
              state     <= cr_popped ? APPEND : SEND;
              cr_popped <= 1'b0;
`else
              state <= SEND;
`endif
            end
          end
`ifdef UART_LINE_ECHO_CRLF_EN
          APPEND: begin
            if (!tx_busy) begin
              tx_byte   <= PAYLOAD_BITS'(ASCII_LF);
              tx_enable <= 1'b1;
              guard     <= 1'b1;
              state     <= WAIT;
            end
          end
`endif
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_line_echo.sv
`timescale 1ns/1ps
module tb_uart_line_echo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_break = 1'b0;
  logic          tx_busy = 1'b0;
  logic          tx_enable;
  logic [7:0]    tx_byte;
  logic [LW-1:0] level;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  bit hold_busy = 1'b0;
  bit prev_en = 1'b0;
  int consec_en = 0;
  int first_en_cyc = -1;
  logic [7:0] txq[$];
  logic [7:0] expq[$];

  uart_line_echo #(
    .DEPTH        (DEPTH),
    .PAYLOAD_BITS (8),
    .TERMINATOR   (8'h0D)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_break  (rx_break),
    .tx_busy   (tx_busy),
    .tx_enable (tx_enable),
    .tx_byte   (tx_byte),
    .level     (level),
    .overflow  (overflow)
  );

  initial forever #5 clock = ~clock;

  // Transmitter model and echo monitor: samples 1 ns after each rising edge.
  initial forever begin
    @(posedge clock);
    cyc++;
    #1;
    if (tx_enable) begin
      if (prev_en) consec_en++;
      if (txq.size() == 0) first_en_cyc = cyc;
      txq.push_back(tx_byte);
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_en = tx_enable;
    tx_busy = hold_busy || (busy_cnt > 0);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic exp_add(input logic [7:0] b);
    expq.push_back(b);
`ifdef UART_LINE_ECHO_CRLF_EN
    if (b == 8'h0D) expq.push_back(8'h0A);
`endif
  endtask

  task automatic wait_echo(input int budget);
    int n = 0;
    while (txq.size() < expq.size() && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL echo_timeout: got %0d bytes, expected %0d", txq.size(), expq.size());
    end
    repeat (30) tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL rst_tx_enable: got %0b expected 0", tx_enable); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rst_tx_byte: got %0h expected 00", tx_byte); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
    reset = 1'b0;
    tick();
    checks++; if (dut.state !== FILL) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dut.state, FILL); end
  endtask

  task automatic test_basic_line();
    int strobe_cyc;
    txq.delete(); expq.delete();
    exp_add(8'h48); exp_add(8'h69); exp_add(8'h0D);
    send_byte(8'h48);
    send_byte(8'h69);
    strobe_cyc = cyc;
    send_byte(8'h0D);
    wait_echo(200);
    checks++; if (first_en_cyc - strobe_cyc != 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", first_en_cyc - strobe_cyc); end
    checks++; if (txq.size() != expq.size()) begin errors++; $display("FAIL basic_count: got %0d expected %0d", txq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
      checks++; if (txq[i] !== expq[i]) begin errors++; $display("FAIL basic_byte%0d: got %0h expected %0h", i, txq[i], expq[i]); end
    end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL basic_level: got %0d expected 0", level); end
    checks++; if (dut.state !== FILL) begin errors++; $display("FAIL basic_state: got %0d expected %0d", dut.state, FILL); end
    checks++; if (tx_byte !== expq[expq.size()-1]) begin errors++; $display("FAIL basic_tx_hold: got %0h expected %0h", tx_byte, expq[expq.size()-1]); end
  endtask

  task automatic test_fill();
    txq.delete(); expq.delete();
    for (int i = 0; i < 16; i++) begin
      exp_add(8'(i));
      send_byte(8'(i));
    end
    wait_echo(500);
    checks++; if (txq.size() != expq.size()) begin errors++; $display("FAIL fill_count: got %0d expected %0d", txq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
      checks++; if (txq[i] !== expq[i]) begin errors++; $display("FAIL fill_byte%0d: got %0h expected %0h", i, txq[i], expq[i]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow: got %0b expected 0", overflow); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL fill_level: got %0d expected 0", level); end
  endtask

  task automatic test_overflow();
    txq.delete(); expq.delete();
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      exp_add(8'(8'h40 + i));
      send_byte(8'(8'h40 + i));
    end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_full_level: got %0d expected 16", level); end
    checks++; if (dut.state !== SEND) begin errors++; $display("FAIL ovf_full_state: got %0d expected %0d", dut.state, SEND); end
    send_byte(8'h60);
    send_byte(8'h61);
    send_byte(8'h62);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    hold_busy = 1'b0;
    wait_echo(500);
    checks++; if (txq.size() != expq.size()) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", txq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
      checks++; if (txq[i] !== expq[i]) begin errors++; $display("FAIL ovf_byte%0d: got %0h expected %0h", i, txq[i], expq[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
  endtask

  task automatic test_break();
    int n = 0;
    txq.delete(); expq.delete();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h31 + i));
    send_byte(8'h0D);
    while (txq.size() < 1 && n < 50) begin tick(); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL brk_timeout: got %0d bytes expected 1", txq.size()); end
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL brk_pre_level: got %0d expected 5", level); end
    checks++; if (dut.state !== WAIT) begin errors++; $display("FAIL brk_pre_state: got %0d expected %0d", dut.state, WAIT); end
    rx_break = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h77;
    tick();
    rx_break = 1'b0;
    rx_valid = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL brk_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL brk_overflow: got %0b expected 0", overflow); end
    checks++; if (dut.state !== FILL) begin errors++; $display("FAIL brk_state: got %0d expected %0d", dut.state, FILL); end
    checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL brk_tx_enable: got %0b expected 0", tx_enable); end
    repeat (40) tick();
    checks++; if (txq.size() != 1) begin errors++; $display("FAIL brk_no_more_tx: got %0d bytes expected 1", txq.size()); end
    checks++; if (txq.size() > 0 && txq[0] !== 8'h31) begin errors++; $display("FAIL brk_first_byte: got %0h expected 31", txq[0]); end
  endtask

  task automatic test_overlap();
    logic [LW-1:0] lvl;
    txq.delete(); expq.delete();
    for (int i = 0; i < 9; i++) begin
      exp_add(8'(8'h80 + i));
      send_byte(8'(8'h80 + i));
    end
    exp_add(8'h0D);
    send_byte(8'h0D);
    for (int k = 0; k < 12; k++) begin
      int n = 0;
      while (!(dut.state == SEND && level != '0) && n < 100) begin tick(); n++; end
      checks++; if (n >= 100) begin errors++; $display("FAIL ovl_timeout%0d: got no SEND expected SEND", k); end
      lvl = level;
      exp_add(8'(8'h90 + k));
      rx_valid = 1'b1;
      rx_byte  = 8'(8'h90 + k);
      tick();
      rx_valid = 1'b0;
      checks++; if (level !== lvl) begin errors++; $display("FAIL ovl_level%0d: got %0d expected %0d", k, level, lvl); end
      checks++; if (tx_enable !== 1'b1) begin errors++; $display("FAIL ovl_pop%0d: got %0b expected 1", k, tx_enable); end
    end
    wait_echo(800);
    checks++; if (txq.size() != expq.size()) begin errors++; $display("FAIL ovl_count: got %0d expected %0d", txq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
      checks++; if (txq[i] !== expq[i]) begin errors++; $display("FAIL ovl_byte%0d: got %0h expected %0h", i, txq[i], expq[i]); end
    end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovl_level_end: got %0d expected 0", level); end
  endtask

  task automatic test_crlf();
    txq.delete(); expq.delete();
    exp_add(8'h41); exp_add(8'h0D);
    send_byte(8'h41);
    send_byte(8'h0D);
    wait_echo(200);
    checks++; if (txq.size() != expq.size()) begin errors++; $display("FAIL crlf_count: got %0d expected %0d", txq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
      checks++; if (txq[i] !== expq[i]) begin errors++; $display("FAIL crlf_byte%0d: got %0h expected %0h", i, txq[i], expq[i]); end
    end
    checks++; if (consec_en != 0) begin errors++; $display("FAIL tx_enable_spacing: got %0d back-to-back strobes expected 0", consec_en); end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_fill();
    test_overflow();
    test_break();
    test_overlap();
    test_crlf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
